// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Resolves the pipeline hazards that EX-stage forwarding cannot cover:
// a one-cycle bubble for load-use dependencies, an IF/ID + ID/EX flush for
// taken branches/jumps resolved in EX, and a whole-pipe freeze while a
// multi-cycle data-memory access is outstanding. Also carries a sticky
// memory-wait watchdog and two saturating performance counters.
//
// Control outputs are combinational so the pipe reacts in the same cycle
// the hazard is seen. Priority, highest first:
//   memory freeze > branch flush > load-use bubble > normal flow.
module hazard_stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 64,  // legal range 2..255
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       if_id_rs1_i,
    input  logic [4:0]       if_id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             id_ex_MemRead_i,
    input  logic [4:0]       id_ex_rd_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             err_clear_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             id_ex_write_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_bubble_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    // RUN: normal flow. MEM_WAIT: a data-memory access has been stalling
    // for at least one edge; wait_cnt tracks how long.
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    localparam logic [7:0] WAIT_MAX     = 8'hFF;
    // Watchdog fires on the edge that completes the MEM_TIMEOUT-th stalled cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic       mem_stall;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;
    logic       flush_issue;
    logic       bubble_issue;

    // Hazard detection. x0 is hard-wired zero, so a load to x0 never
    // creates a dependency.
    assign mem_stall    = mem_req_i && !mem_ready_i;
    assign rs1_hit      = id_uses_rs1_i && (id_ex_rd_i == if_id_rs1_i);
    assign rs2_hit      = id_uses_rs2_i && (id_ex_rd_i == if_id_rs2_i);
    assign load_use     = id_ex_MemRead_i && (id_ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);

    // A branch seen during a freeze is held in EX and re-presented later,
    // so it only counts as a flush when the pipe is moving. A load-use
    // coinciding with a flush is moot: the dependent ID instruction dies.
    assign flush_issue  = !mem_stall && ex_branch_taken_i;
    assign bubble_issue = !mem_stall && !ex_branch_taken_i && load_use;

    // Pipeline register controls, forced to free-flow while reset is held.
    always_comb begin
        pc_write_o      = 1'b1;
        if_id_write_o   = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        id_ex_write_o   = 1'b1;
        ex_mem_write_o  = 1'b1;
        mem_wb_bubble_o = 1'b0;
        if (rst_n_i) begin
            if (mem_stall) begin
                // Freeze everything up to EX/MEM; MEM/WB gets a NOP so the
                // stalled access does not write back twice.
                pc_write_o      = 1'b0;
                if_id_write_o   = 1'b0;
                id_ex_write_o   = 1'b0;
                ex_mem_write_o  = 1'b0;
                mem_wb_bubble_o = 1'b1;
            end else if (ex_branch_taken_i) begin
                // PC loads the target; the two younger instructions become NOPs.
                if_id_flush_o   = 1'b1;
                id_ex_bubble_o  = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID for one cycle and slip a NOP into EX.
                pc_write_o      = 1'b0;
                if_id_write_o   = 1'b0;
                id_ex_bubble_o  = 1'b1;
            end
        end
    end

    // Next-state logic for the memory-wait FSM and the watchdog.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    wait_cnt_d = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 8'd1;
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
        // Setting beats clearing when both happen on the same edge, so a
        // fresh timeout is never lost to a stale clear request.
        if (mem_stall && (wait_cnt_q == TIMEOUT_LAST)) begin
            mem_timeout_d = 1'b1;
        end else if (err_clear_i) begin
            mem_timeout_d = 1'b0;
        end
    end

    // FSM state, wait counter and sticky watchdog flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout_o = mem_timeout_q;

    // Counter events: [0] stall cycles (memory wait or load-use bubble),
    // [1] branch flushes actually issued.
    logic [1:0] cnt_inc;
    assign cnt_inc[0] = mem_stall || bubble_issue;
    assign cnt_inc[1] = flush_issue;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Saturate at all-ones rather than wrap so a long run never
            // reports a misleadingly small figure.
            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Performance counter register.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign stall_cycles_o = g_cnt[0].cnt_q;
    assign flush_count_o  = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Testbench for hazard_stall_controller: directed scenarios followed by
// randomized traffic, all checked against a behavioural model. Two
// instances share the stimulus: one with wide counters, one with 2-bit
// counters to exercise saturation.
module tb_hazard_stall_controller;

    localparam int MT    = 4;
    localparam int W_MAIN = 16;
    localparam int W_SAT  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
    logic       id_uses_rs1, id_uses_rs2, id_ex_MemRead;
    logic       ex_branch_taken, mem_req, mem_ready, err_clear;

    logic              m_pc, m_ifw, m_iff, m_bub, m_idw, m_exw, m_wbb, m_to;
    logic [W_MAIN-1:0] m_stall, m_flush;
    logic              s_pc, s_ifw, s_iff, s_bub, s_idw, s_exw, s_wbb, s_to;
    logic [W_SAT-1:0]  s_stall, s_flush;

    int n_assert = 0;
    int n_fail   = 0;
    int n_step   = 0;

    // Reference model state
    int stall_main, flush_main, stall_sat, flush_sat, stall_run;
    bit timeout_m;

    always #5 clk = ~clk;

    hazard_stall_controller #(.MEM_TIMEOUT(MT), .CNT_W(W_MAIN)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_id_rs1_i(if_id_rs1), .if_id_rs2_i(if_id_rs2),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .id_ex_MemRead_i(id_ex_MemRead), .id_ex_rd_i(id_ex_rd),
        .ex_branch_taken_i(ex_branch_taken),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready), .err_clear_i(err_clear),
        .pc_write_o(m_pc), .if_id_write_o(m_ifw), .if_id_flush_o(m_iff),
        .id_ex_bubble_o(m_bub), .id_ex_write_o(m_idw), .ex_mem_write_o(m_exw),
        .mem_wb_bubble_o(m_wbb), .mem_timeout_o(m_to),
        .stall_cycles_o(m_stall), .flush_count_o(m_flush)
    );

    hazard_stall_controller #(.MEM_TIMEOUT(MT), .CNT_W(W_SAT)) dut_sat (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_id_rs1_i(if_id_rs1), .if_id_rs2_i(if_id_rs2),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .id_ex_MemRead_i(id_ex_MemRead), .id_ex_rd_i(id_ex_rd),
        .ex_branch_taken_i(ex_branch_taken),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready), .err_clear_i(err_clear),
        .pc_write_o(s_pc), .if_id_write_o(s_ifw), .if_id_flush_o(s_iff),
        .id_ex_bubble_o(s_bub), .id_ex_write_o(s_idw), .ex_mem_write_o(s_exw),
        .mem_wb_bubble_o(s_wbb), .mem_timeout_o(s_to),
        .stall_cycles_o(s_stall), .flush_count_o(s_flush)
    );

    function automatic bit model_mem_stall();
        return mem_req && !mem_ready;
    endfunction

    function automatic bit model_load_use();
        bit dep1, dep2;
        dep1 = id_uses_rs1 && (id_ex_rd == if_id_rs1);
        dep2 = id_uses_rs2 && (id_ex_rd == if_id_rs2);
        return id_ex_MemRead && (id_ex_rd != 5'd0) && (dep1 || dep2);
    endfunction

    // Expected {pc_write, if_id_write, if_id_flush, id_ex_bubble,
    //           id_ex_write, ex_mem_write, mem_wb_bubble}
    function automatic logic [6:0] exp_ctrl();
        if (!rst_n)             return 7'b1100110;
        if (model_mem_stall())  return 7'b0000001;
        if (ex_branch_taken)    return 7'b1111110;
        if (model_load_use())   return 7'b0001110;
        return 7'b1100110;
    endfunction

    function automatic int sat_inc(int v, int w);
        int top;
        top = (1 << w) - 1;
        return (v < top) ? v + 1 : v;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (step %0d)", tag, obs, expv, n_step);
        end
    endtask

    task automatic check_all();
        logic [6:0] e;
        e = exp_ctrl();
        check("ctrl",        32'({m_pc, m_ifw, m_iff, m_bub, m_idw, m_exw, m_wbb}), 32'(e));
        check("sat_ctrl",    32'({s_pc, s_ifw, s_iff, s_bub, s_idw, s_exw, s_wbb}), 32'(e));
        check("stall_cnt",   32'(m_stall), 32'(stall_main));
        check("flush_cnt",   32'(m_flush), 32'(flush_main));
        check("sat_stall",   32'(s_stall), 32'(stall_sat));
        check("sat_flush",   32'(s_flush), 32'(flush_sat));
        check("timeout",     32'(m_to), 32'(timeout_m));
        check("sat_timeout", 32'(s_to), 32'(timeout_m));
        $display("step %0d rst_n=%b ctrl=%b stall=%0d flush=%0d timeout=%b",
                 n_step, rst_n, {m_pc, m_ifw, m_iff, m_bub, m_idw, m_exw, m_wbb},
                 m_stall, m_flush, m_to);
    endtask

    // Advance the model by one rising edge using the inputs seen before it.
    task automatic model_edge();
        bit ms, lu, set;
        ms = model_mem_stall();
        lu = model_load_use();
        if (ms || (lu && !ex_branch_taken)) begin
            stall_main = sat_inc(stall_main, W_MAIN);
            stall_sat  = sat_inc(stall_sat, W_SAT);
        end
        if (!ms && ex_branch_taken) begin
            flush_main = sat_inc(flush_main, W_MAIN);
            flush_sat  = sat_inc(flush_sat, W_SAT);
        end
        stall_run = ms ? stall_run + 1 : 0;
        set = ms && (stall_run == MT);
        if (set)            timeout_m = 1'b1;
        else if (err_clear) timeout_m = 1'b0;
    endtask

    task automatic model_reset();
        stall_main = 0; flush_main = 0; stall_sat = 0; flush_sat = 0;
        stall_run = 0; timeout_m = 1'b0;
    endtask

    task automatic idle();
        if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; id_ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_ex_MemRead = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; err_clear = 1'b0;
    endtask

    // One transaction: inputs already driven; check mid-cycle, then clock.
    task automatic step();
        n_step++;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Asynchronous reset between clock edges, checked while still asserted.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_step++;
        check_all();
        idle();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    int burst;

    initial begin
        idle();
        model_reset();
        do_reset();

        // Load-use: one bubble cycle, then free flow.
        id_ex_MemRead = 1'b1; id_ex_rd = 5'd5; if_id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        step();
        id_ex_MemRead = 1'b0;
        step();
        check("lu_count", 32'(m_stall), 32'd1);

        // Load to x0, and load whose rd is not actually read: no stall.
        id_ex_MemRead = 1'b1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        step();
        id_ex_rd = 5'd5; if_id_rs1 = 5'd5; id_uses_rs1 = 1'b0;
        step();
        idle();
        step();
        check("x0_count", 32'(m_stall), 32'd1);

        // Branch together with a load-use match: flush wins.
        id_ex_MemRead = 1'b1; id_ex_rd = 5'd7; if_id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        ex_branch_taken = 1'b1;
        step();
        idle();
        step();
        check("br_flush", 32'(m_flush), 32'd1);
        check("br_stall", 32'(m_stall), 32'd1);

        // Memory wait with a branch pending: 3 frozen cycles, then flush.
        ex_branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        repeat (3) step();
        mem_ready = 1'b1;
        step();
        idle();
        step();
        check("mw_stall", 32'(m_stall), 32'd4);
        check("mw_flush", 32'(m_flush), 32'd2);

        // Watchdog: 6 stalled cycles, clear coinciding with the setting edge.
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (3) step();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        repeat (2) step();
        mem_ready = 1'b1;
        step();
        idle();
        step();
        check("wd_sticky", 32'(m_to), 32'd1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        step();
        check("wd_cleared", 32'(m_to), 32'd0);

        // Flush-count saturation on the 2-bit instance.
        ex_branch_taken = 1'b1;
        repeat (5) step();
        idle();
        step();
        check("sat_flush3", 32'(s_flush), 32'd3);
        check("main_flush", 32'(m_flush), 32'd7);

        // Asynchronous reset in the middle of a memory wait.
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (2) step();
        do_reset();
        step();

        // Randomized traffic with occasional long memory stalls and resets.
        burst = 0;
        for (int i = 0; i < 400; i++) begin
            if_id_rs1       = 5'($urandom_range(0, 3));
            if_id_rs2       = 5'($urandom_range(0, 3));
            id_ex_rd        = 5'($urandom_range(0, 3));
            id_uses_rs1     = ($urandom_range(0, 1) == 1);
            id_uses_rs2     = ($urandom_range(0, 1) == 1);
            id_ex_MemRead   = ($urandom_range(0, 1) == 1);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            err_clear       = ($urandom_range(0, 7) == 0);
            if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(3, 7);
            if (burst > 0) begin
                mem_req = 1'b1; mem_ready = 1'b0; burst--;
            end else begin
                mem_req   = ($urandom_range(0, 2) == 0);
                mem_ready = ($urandom_range(0, 1) == 1);
            end
            if ($urandom_range(0, 99) == 0) begin
                burst = 0;
                do_reset();
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline-control companion to the EX-stage forwarding logic.
- Covers the hazards forwarding cannot resolve:
  - load-use dependencies, by stalling one cycle with a bubble;
  - taken branches/jumps in EX, by flushing IF/ID and ID/EX;
  - multi-cycle data-memory accesses, by freezing the whole pipe on a req/ready handshake.
- Also provides a memory-wait watchdog and saturating performance counters.

Parameters:
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before mem_timeout asserts; legal range 2..255.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_id_rs1  input  5  rs1 field of the instruction in ID.
- if_id_rs2  input  5  rs2 field of the instruction in ID.
- id_uses_rs1  input  1  ID instruction reads rs1.
- id_uses_rs2  input  1  ID instruction reads rs2.
- id_ex_MemRead  input  1  instruction in EX is a load.
- id_ex_rd  input  5  rd of the instruction in EX.
- ex_branch_taken  input  1  EX resolved a taken branch/jump this cycle.
- mem_req  input  1  MEM stage holds a valid load/store.
- mem_ready  input  1  data memory completes the access this cycle.
- err_clear  input  1  clears the sticky mem_timeout.
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID load enable.
- if_id_flush  output  1  IF/ID loads a NOP.
- id_ex_bubble  output  1  ID/EX loads a NOP; covers both flush and load-use bubble.
- id_ex_write  output  1  ID/EX load enable.
- ex_mem_write  output  1  EX/MEM load enable.
- mem_wb_bubble  output  1  MEM/WB loads a NOP (RegWrite=0).
- mem_timeout  output  1  sticky watchdog error.
- stall_cycles  output  CNT_W  saturating count of load-use and memory-wait cycles.
- flush_count  output  CNT_W  saturating count of branch flushes.

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, wait_cnt=0, mem_timeout=0, both counters=0.
  - Combinational outputs during reset: all enables=1, all flush/bubble=0.
- States are RUN and MEM_WAIT, encoded in 1 bit.
- Signal derivation:
  - mem_stall = mem_req && !mem_ready, evaluated combinationally in both states.
  - load_use = id_ex_MemRead && id_ex_rd!=0 && ((id_uses_rs1 && id_ex_rd==if_id_rs1) || (id_uses_rs2 && id_ex_rd==if_id_rs2)).
- Priority, highest first; outputs are combinational, same cycle:
  1. mem_stall (freeze):
     - pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_write=0.
     - mem_wb_bubble=1.
     - if_id_flush=0, id_ex_bubble=0.
     - ex_branch_taken is ignored; EX is held, so the branch is re-presented after the freeze.
  2. ex_branch_taken (flush):
     - if_id_flush=1, id_ex_bubble=1.
     - pc_write=1 (target load), if_id_write=1, id_ex_write=1, ex_mem_write=1.
     - Any coincident load_use is discarded, because its ID instruction is squashed.
  3. load_use (bubble):
     - pc_write=0, if_id_write=0, id_ex_bubble=1.
     - ex_mem_write=1, id_ex_write=1.
     - Exactly one cycle per dependency: next cycle id_ex_MemRead=0, so the condition self-clears.
  4. Otherwise: all enables=1, flush/bubble=0, mem_wb_bubble=0.
- FSM transitions:
  - RUN -> MEM_WAIT when mem_stall; wait_cnt is loaded with 1.
  - MEM_WAIT, mem_stall still true: stay; wait_cnt increments, saturating at 255.
  - MEM_WAIT, mem_ready=1 or mem_req=0: go to RUN; wait_cnt=0.
- Watchdog:
  - mem_timeout sets on the edge where wait_cnt==MEM_TIMEOUT-1 and mem_stall is still true.
  - It is sticky; err_clear=1 clears it at the next edge.
  - If set and clear coincide, set wins.
  - The pipe freeze continues regardless of mem_timeout.
- Counters (saturate at all-ones, no wrap):
  - stall_cycles +1 on each cycle with mem_stall, or with load_use without a flush.
  - flush_count +1 on each cycle where a flush is actually issued (priority 2 taken).
- x0: load_use never triggers on rd=0.
- Reset mid-MEM_WAIT: returns to RUN, wait_cnt=0; counters and mem_timeout cleared.

Test Plan:
- Load-use dependency:
  - Stimulus: id_ex_MemRead=1, id_ex_rd=5, if_id_rs1=5, id_uses_rs1=1.
  - Response: for exactly 1 cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle (MemRead=0) all enables=1; stall_cycles=1.
- Load to x0:
  - Stimulus: same as above with id_ex_rd=0, or with id_uses_rs1=0.
  - Response: no stall; stall_cycles stays 0.
- Branch vs. load-use:
  - Stimulus: ex_branch_taken=1 together with a load_use match.
  - Response: if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count=1; stall_cycles unchanged.
- Memory wait:
  - Stimulus: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1, with ex_branch_taken=1 throughout.
  - Response: 3 frozen cycles with mem_wb_bubble=1 and no flush; on the ready cycle the flush issues; stall_cycles=3; state returns to RUN.
- Watchdog:
  - Stimulus: MEM_TIMEOUT=4, mem_stall held for 6 cycles.
  - Response: mem_timeout rises after the 4th stalled edge and stays high after mem_ready; one err_clear pulse clears it.
- Reset and saturation:
  - Stimulus 1: assert rst_n=0 asynchronously mid-MEM_WAIT. Response: immediately state=RUN, counters=0, mem_timeout=0.
  - Stimulus 2: CNT_W=2 with 5 flushes. Response: flush_count saturates at 3.
